// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit. It computes one product or quotient bit per cycle.
// Optional macro ALU_MULDIV_EARLY_OUT_EN sends trivial operands (zero operand, divide-by-zero, overflow) straight to DONE.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, div0;

    function automatic logic [WIDTH-1:0] cneg_w(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic neg, input logic [2*WIDTH-1:0] x);
        return neg ? -x : x;
    endfunction

    // Operand decode: the iteration runs on magnitudes and the sign is fixed afterwards.
    logic             is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    always_comb begin
        is_div = op[2];
        a_sgn  = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        b_sgn  = is_div ? ~op[0] : (op[1:0] == 2'b01);
        a_neg  = a_sgn && ($signed(a) < 0);
        b_neg  = b_sgn && ($signed(b) < 0);
        a_mag  = cneg_w(a_neg, a);
        b_mag  = cneg_w(b_neg, b);
        b_zero = (b == '0);
    end

    // One shift-add or restoring-divide step. The result comes from the step that ends CALC.
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] acc_nxt, prod;
    logic [WIDTH-1:0]   quo, rem, final_res;
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (op_q[2])
            acc_nxt = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        prod = cneg_2w(neg_q, acc_nxt);
        quo  = div0 ? '1 : cneg_w(neg_q, acc_nxt[WIDTH-1:0]);
        rem  = cneg_w(neg_r, acc_nxt[2*WIDTH-1:WIDTH]);
        if (op_q[2])
            final_res = op_q[1] ? rem : quo;
        else
            final_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

`ifdef ALU_MULDIV_EARLY_OUT_EN
    logic             ovf, early;
    logic [WIDTH-1:0] early_res;
    always_comb begin
        ovf       = is_div && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        early     = ovf || (a == '0) || b_zero;
        early_res = '0;
        if (is_div && b_zero)
            early_res = op[1] ? a : '1;
        else if (ovf)
            early_res = op[1] ? '0 : a;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        opnd  <= is_div ? b_mag : a_mag;
                        acc   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        div0  <= is_div && b_zero;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                        if (early) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= early_res;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= final_res;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign zero = (result == '0);
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv (WIDTH=32); latency expectations follow ALU_MULDIV_EARLY_OUT_EN.
`timescale 1ns/1ps
module tb_alu_muldiv;
    localparam int W = 32;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero;
    logic [W-1:0] result;
    int           errs = 0;
    int           checks = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic trivial;
        trivial = (x == '0) || (y == '0) ||
                  (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        return (EARLY && trivial) ? 1 : W + 1;
    endfunction

    // Start one operation from IDLE, scramble inputs after acceptance, wait for done, return to IDLE.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] res, output logic z, output int lat);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        res = result;
        z   = zero;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== '0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (zero !== 1'b1) begin errs++; $display("FAIL reset_zero: got %b want 1", zero); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mulh_timing();
        int busy_bad = 0, done_cnt = 0, done_cyc = -1;
        logic [W-1:0] res_at_done = '0;
        op = 3'b001; a = 32'h8000_0000; b = 32'h8000_0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy !== (c <= 33)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                res_at_done = result;
            end
            tick();
        end
        checks++; if (busy_bad != 0) begin errs++; $display("FAIL mulh_busy_window: got %0d bad cycles want 0", busy_bad); end
        checks++; if (done_cnt != 1) begin errs++; $display("FAIL mulh_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc != 33) begin errs++; $display("FAIL mulh_done_cycle: got %0d want 33", done_cyc); end
        checks++; if (res_at_done !== 32'h4000_0000) begin errs++; $display("FAIL mulh_result: got %h want 40000000", res_at_done); end
    endtask

    task automatic test_mul();
        vec_t v [6];
        logic [W-1:0] res; logic z; int lat;
        v = '{'{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
              '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780},
              '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
              '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
              '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
              '{3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat);
            checks++; if (res !== v[i].exp) begin errs++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, v[i].exp); end
            checks++; if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin errs++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b)); end
            checks++; if (z !== (v[i].exp == '0)) begin errs++; $display("FAIL mul_zero[%0d]: got %b want %b", i, z, (v[i].exp == '0)); end
        end
    endtask

    task automatic test_div();
        vec_t v [7];
        logic [W-1:0] res; logic z; int lat;
        v = '{'{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
              '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
              '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
              '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001},
              '{3'b101, 32'd100,       32'd7,         32'd14},
              '{3'b111, 32'd100,       32'd7,         32'd2},
              '{3'b101, 32'd0,         32'd9,         32'd0}};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat);
            checks++; if (res !== v[i].exp) begin errs++; $display("FAIL div_result[%0d]: got %h want %h", i, res, v[i].exp); end
            checks++; if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin errs++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b)); end
        end
    endtask

    task automatic test_div_special();
        vec_t v [6];
        logic [W-1:0] res; logic z; int lat;
        v = '{'{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF},
              '{3'b111, 32'd5,         32'd0,         32'd5},
              '{3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
              '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
              '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
              '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat);
            checks++; if (res !== v[i].exp) begin errs++; $display("FAIL divspec_result[%0d]: got %h want %h", i, res, v[i].exp); end
            checks++; if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin errs++; $display("FAIL divspec_latency[%0d]: got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b)); end
            checks++; if (z !== (v[i].exp == '0)) begin errs++; $display("FAIL divspec_zero[%0d]: got %b want %b", i, z, (v[i].exp == '0)); end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] res; logic z; int lat; int seen = 0; int n;
        run_op(3'b000, 32'd3, 32'd5, res, z, lat);
        checks++; if (res !== 32'd15) begin errs++; $display("FAIL flush_setup: got %h want 0000000f", res); end
        op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (done === 1'b1) seen++;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (seen != 0) begin errs++; $display("FAIL flush_done: got %0d pulses want 0", seen); end
        checks++; if (result !== 32'd15) begin errs++; $display("FAIL flush_result_held: got %h want 0000000f", result); end
        tick();
        op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL flush_restart_busy: got %b want 1", busy); end
        n = 1;
        while (!done && n < 60) begin tick(); n++; end
        checks++; if (result !== 32'hFFFF_FFFE || done !== 1'b1) begin errs++; $display("FAIL flush_restart_result: got %h done=%b want fffffffe done=1", result, done); end
        tick();
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_start_conflict: got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 19; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result !== '0 || zero !== 1'b1) begin errs++; $display("FAIL midreset_result: got %h zero=%b want 0 zero=1", result, zero); end
        op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (done === 1'b1) dones++;
            start = (c >= 5 && c <= 30);
            tick();
        end
        start = 1'b0;
        checks++; if (dones != 1) begin errs++; $display("FAIL start_held_dones: got %0d want 1", dones); end
        checks++; if (result !== 32'd12) begin errs++; $display("FAIL start_held_result: got %h want 0000000c", result); end
    endtask

    task automatic test_back_to_back();
        int n = 1;
        op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && n < 60) begin tick(); n++; end
        checks++; if (result !== 32'd14 || done !== 1'b1) begin errs++; $display("FAIL b2b_first: got %h done=%b want 0000000e done=1", result, done); end
        op = 3'b111; start = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        n = 1;
        while (!done && n < 60) begin tick(); n++; end
        checks++; if (result !== 32'd2 || done !== 1'b1) begin errs++; $display("FAIL b2b_second: got %h done=%b want 00000002 done=1", result, done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mulh_timing();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
